mac_accum_l1: RTL and testbench
===============================

// Module: mac_accum_l1
// PURPOSE
//  Level-1 multiply-accumulate stage. Consumes the 16-bit sample stream from the level-1 delay line,
//  one sample per tap, and multiplies each sample by a signed coefficient. It accumulates TAPS
//  products into one result and emits a 16-bit scaled result through a valid/ready handshake.
//  Sits directly downstream of the L1 shift delay line; feeds the L2 combiner.
// PARAMETERS
//  TAPS        6   products per result; range 2..64; matches the L1 delay depth
//  ACC_W       40  accumulator width in bits; must be >= 32+clog2(TAPS)
//  FRAC_SHIFT  15  arithmetic right shift applied to the final sum before output (Q15 coefs)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  clear      in   1      sync flush of partial accumulation
//  in_valid   in   1      sample/coef pair valid
//  in_ready   out  1      block can accept a pair this cycle
//  data_in    in   16     signed sample from the delay line
//  coef_in    in   16     signed coefficient for the current tap
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  data_out   out  16     signed scaled result
//  out_ovf    out  1      result exceeded the 16-bit range (valid with out_valid)
// BEHAVIOUR
//  - Reset (rst_n=0, async): in_ready=0 while rst_n=0; in_ready=1 from the first edge after release.
//    out_valid=0, data_out=0, out_ovf=0, tap_cnt=0, acc=0, all pipeline valids=0.
//  - Accept: a pair is taken when in_valid & in_ready. in_ready = !clear & !(out_valid & !out_ready).
//  - Stage 1 (S1): registers prod = data_in*coef_in as a 32-bit signed value, tagged first/last from tap_cnt.
//  - tap_cnt runs 0..TAPS-1 and advances on each accept. It wraps to 0 after TAPS-1.
//  - Stage 2 (S2) when S1 valid:
//    - first tag: acc <= sext(prod).
//    - otherwise: acc <= acc + sext(prod), with wrap at ACC_W.
//    - last tag: sum = acc + sext(prod); the output register loads from sum; out_valid <= 1.
//  - Latency: last pair accepted in cycle t -> out_valid=1 in cycle t+2. Throughput is 1 pair/cycle.
//  - Output FSM, states EMPTY/FULL:
//    - EMPTY->FULL when S2 completes a result.
//    - FULL->EMPTY on out_ready, unless a new result completes the same cycle; then it stays FULL
//      with the new data.
//    - data_out/out_ovf hold stable while out_valid & !out_ready.
//  - Stall: while out_valid & !out_ready, in_ready=0 and S1/S2 freeze. No product or partial sum is
//    lost or duplicated.
//  - Scaling: s = sum >>> FRAC_SHIFT (arithmetic shift, truncation toward -inf). Range check is
//    against [-32768, 32767].
//  - clear=1:
//    - tap_cnt<=0, S1/S2 valids<=0, acc<=0; the partial result is discarded; in_ready=0 that cycle.
//    - A pending FULL result is kept and still delivered.
//    - clear with S2 completing on the same edge: clear wins and no result is produced.
//  - Reset mid-operation: all state is dropped immediately; the first pair after reset is tap 0.
// CONFIGURATION
//  MAC_L1_SAT_EN defined:
//    - data_out = s clamped to 0x7FFF / 0x8000 when out of range; out_ovf=1 if clamped, else 0.
//  MAC_L1_SAT_EN undefined:
//    - data_out = s[15:0] (wraps); out_ovf is tied 0; the saturation logic is absent.
// TESTING
//  1. 6 back-to-back pairs data=0x1000, coef=0x4000 -> one result, out_valid 2 cycles after the
//     6th accept; data_out=0x3000, out_ovf=0.
//  2. 6 pairs 0x7FFF*0x7FFF:
//     - SAT_EN: data_out=0x7FFF, out_ovf=1.
//     - no SAT_EN: data_out=0xFFF4, out_ovf=0.
//  3. Two results back-to-back (12 pairs), out_ready=0 for 5 cycles after the first out_valid ->
//     - in_ready low while stalled; first result held unchanged;
//     - second result appears after the release; no pair lost.
//  4. Alternating data=+0x2000/-0x2000 with coef=0x7FFF, in_valid toggling every cycle ->
//     data_out=0x0000; tap counting is unaffected by gaps.
//  5. clear asserted after 3 of 6 pairs, then 6 pairs of 0x1000*0x4000 ->
//     - no result from the first 3 pairs;
//     - next result data_out=0x3000.
//  6. rst_n pulsed low mid-accumulation (after 4 pairs) -> outputs go to 0 asynchronously;
//     the next 6 pairs produce a clean result equal to test 1.

Source files
------------

// File: rtl/mac_accum_l1.sv
// mac_accum_l1 -- level-1 multiply-accumulate stage.
// Takes one signed sample/coefficient pair per tap from the L1 delay line.
// Each group of TAPS products is summed into one result. The result is scaled
// down by FRAC_SHIFT and handed to the L2 combiner over a valid/ready handshake.
// Pipeline: S1 registers the product, S2 accumulates, then the output register
// is controlled by a two-state EMPTY/FULL FSM.
// Optional feature macro: MAC_L1_SAT_EN. When it is defined, the output
// saturates to 16 bits and out_ovf flags a clamp. When it is undefined, the
// output wraps to 16 bits and out_ovf is tied low.
module mac_accum_l1 #(
   parameter int TAPS       = 6,
   parameter int ACC_W      = 40,
   parameter int FRAC_SHIFT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] data_in,
   input  logic [15:0] coef_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] data_out,
   output logic        out_ovf
);

   // Tap counter width; TAPS is at least 2, so clog2 is never zero.
   localparam int              CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

`ifdef MAC_L1_SAT_EN
   // 16-bit signed range bounds, extended to accumulator width for comparison.
   localparam logic signed [ACC_W-1:0] S16_MAX = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] S16_MIN = ACC_W'(-32'sd32768);

   // Clamp a scaled sum into 16 bits; bit 16 of the result is the clamp flag.
   function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] v);
      logic [16:0] r;
      if (v > S16_MAX) begin
         r = {1'b1, 16'h7FFF};
      end else if (v < S16_MIN) begin
         r = {1'b1, 16'h8000};
      end else begin
         r = {1'b0, v[15:0]};
      end
      return r;
   endfunction
`endif

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Handshake / control
   logic                    rst_done_r;
   logic                    stall_s;
   logic                    in_ready_s;
   logic                    accept_s;
   logic                    s2_fire_s;
   logic                    complete_s;
   logic                    load_out_s;

   // S1: registered product with group position tags
   logic [CNT_W-1:0]        tap_cnt_r;
   logic                    s1_valid_r;
   logic                    s1_first_r;
   logic                    s1_last_r;
   logic signed [31:0]      s1_prod_r;

   // S2: accumulator and running sum
   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] prod_ext_s;
   logic signed [ACC_W-1:0] acc_base_s;
   logic signed [ACC_W-1:0] sum_s;

   // Output stage
   out_state_t              state_r;
   out_state_t              state_nx_s;
   logic                    out_valid_r;
   logic [15:0]             data_out_r;
   logic [15:0]             res_data_s;
`ifdef MAC_L1_SAT_EN
   logic                    res_ovf_s;
   logic                    out_ovf_r;
`endif

   // Handshake decode and the S2 running sum.
   always_comb begin
      stall_s    = out_valid_r & ~out_ready;
      in_ready_s = rst_done_r & ~clear & ~stall_s;
      accept_s   = in_valid & in_ready_s;
      // clear wins over a result completing on the same edge
      s2_fire_s  = s1_valid_r & ~stall_s & ~clear;
      complete_s = s2_fire_s & s1_last_r;
      prod_ext_s = {{(ACC_W-32){s1_prod_r[31]}}, s1_prod_r};
      // the first product of a group restarts the sum instead of adding to stale acc
      if (s1_first_r) begin
         acc_base_s = {ACC_W{1'b0}};
      end else begin
         acc_base_s = acc_r;
      end
      sum_s = acc_base_s + prod_ext_s;
   end

   // Scale the completed sum and format it for the 16-bit output.
   always_comb begin
`ifdef MAC_L1_SAT_EN
      {res_ovf_s, res_data_s} = sat16(sum_s >>> FRAC_SHIFT);
`else
      res_data_s = 16'(sum_s >>> FRAC_SHIFT);
`endif
   end

   // Output FSM next state: load on a completed result, drain on out_ready.
   always_comb begin
      state_nx_s = state_r;
      load_out_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (complete_s) begin
               state_nx_s = ST_FULL;
               load_out_s = 1'b1;
            end else begin
               state_nx_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // a completion here implies no stall, so the old result is being taken
            if (complete_s) begin
               state_nx_s = ST_FULL;
               load_out_s = 1'b1;
            end else if (out_ready) begin
               state_nx_s = ST_EMPTY;
            end else begin
               state_nx_s = ST_FULL;
            end
         end
         default: begin
            state_nx_s = ST_EMPTY;
         end
      endcase
   end

   // Input is held off until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done_r <= 1'b0;
      end else begin
         rst_done_r <= 1'b1;
      end
   end

   // S1: register the product and tag its position within the group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_cnt_r  <= {CNT_W{1'b0}};
         s1_valid_r <= 1'b0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_prod_r  <= 32'sd0;
      end else if (clear) begin
         tap_cnt_r  <= {CNT_W{1'b0}};
         s1_valid_r <= 1'b0;
      end else if (!stall_s) begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_prod_r  <= $signed(data_in) * $signed(coef_in);
            s1_first_r <= (tap_cnt_r == {CNT_W{1'b0}});
            s1_last_r  <= (tap_cnt_r == LAST_TAP);
            if (tap_cnt_r == LAST_TAP) begin
               tap_cnt_r <= {CNT_W{1'b0}};
            end else begin
               tap_cnt_r <= tap_cnt_r + CNT_W'(1'b1);
            end
         end
      end
   end

   // S2: accumulate products; clear drops the partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (clear) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (s2_fire_s) begin
         acc_r <= sum_s;
      end
   end

   // Output register and FSM state; the data holds while FULL and not taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         data_out_r  <= 16'h0000;
`ifdef MAC_L1_SAT_EN
         out_ovf_r   <= 1'b0;
`endif
      end else begin
         state_r     <= state_nx_s;
         out_valid_r <= (state_nx_s == ST_FULL);
         if (load_out_s) begin
            data_out_r <= res_data_s;
`ifdef MAC_L1_SAT_EN
            out_ovf_r  <= res_ovf_s;
`endif
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign data_out  = data_out_r;
`ifdef MAC_L1_SAT_EN
   assign out_ovf   = out_ovf_r;
`else
   assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accum_l1.sv
// tb_mac_accum_l1 -- self-checking bench for mac_accum_l1.
// The reference model sums products of accepted pairs in plain integer
// arithmetic. It emits one expected result per TAPS accepted pairs into a
// queue, and the queue is matched against every output transfer.
module tb_mac_accum_l1;

   localparam int TAPS       = 6;
   localparam int FRAC_SHIFT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] coef_in = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] data_out;
   logic        out_ovf;

   mac_accum_l1 #(.TAPS(TAPS), .ACC_W(40), .FRAC_SHIFT(FRAC_SHIFT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .coef_in   (coef_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_ovf   (out_ovf)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          model_taps = 0;
   longint      model_sum = 0;
   logic [16:0] exp_q[$];
   logic        rst_done;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0000;
   logic        prev_ovf = 1'b0;
   logic        accepted = 1'b0;
   int          last_acc_cyc = 0;
   int          first_ov_cyc = -1;
   int          or_low_left = 0;
   logic        or_rand = 1'b0;
   int          results_seen = 0;
   int          stall_cnt = 0;
   logic [15:0] last_out = 16'h0000;
   logic        last_ovf = 1'b0;

   // Input may be accepted once a clock edge has passed with reset released.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected output for a full group: scale by FRAC_SHIFT, then clamp or wrap.
   function automatic logic [16:0] model_result(input longint sum);
      longint s;
      s = sum >>> FRAC_SHIFT;
`ifdef MAC_L1_SAT_EN
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
`endif
      return {1'b0, s[15:0]};
   endfunction

   task automatic model_accept(input logic [15:0] d, input logic [15:0] c);
      model_sum += longint'($signed(d)) * longint'($signed(c));
      model_taps++;
      if (model_taps == TAPS) begin
         exp_q.push_back(model_result(model_sum));
         model_taps = 0;
         model_sum  = 0;
      end
   endtask

   // One clock: drive inputs on the falling edge, then check settled outputs.
   task automatic step(input logic iv, input logic [15:0] d, input logic [15:0] c, input logic clr);
      logic ordy;
      logic exp_ir;
      logic [16:0] e;
      @(negedge clk);
      cyc++;
      if (or_low_left > 0)  ordy = 1'b0;
      else if (or_rand)     ordy = ($urandom_range(3, 0) != 0);
      else                  ordy = 1'b1;
      in_valid  = iv;
      data_in   = d;
      coef_in   = c;
      clear     = clr;
      out_ready = ordy;
      #1;
      if (prev_stall) begin
         stall_cnt++;
         check_val("hold_valid", {31'd0, out_valid}, 32'd1);
         check_val("hold_data", {16'd0, data_out}, {16'd0, prev_data});
         check_val("hold_ovf", {31'd0, out_ovf}, {31'd0, prev_ovf});
      end
      exp_ir = rst_done & ~clr & ~(out_valid & ~ordy);
      check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid & ordy) begin
         check_val("result_pending", {31'd0, (exp_q.size() > 0)}, 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("out_data", {16'd0, data_out}, {16'd0, e[15:0]});
            check_val("out_ovf", {31'd0, out_ovf}, {31'd0, e[16]});
         end
         results_seen++;
         last_out = data_out;
         last_ovf = out_ovf;
      end
      prev_stall = out_valid & ~ordy;
      prev_data  = data_out;
      prev_ovf   = out_ovf;
      accepted   = iv & in_ready;
      if (accepted) begin
         last_acc_cyc = cyc;
         model_accept(d, c);
      end
      if (clr) begin
         model_taps = 0;
         model_sum  = 0;
      end
      if (or_low_left > 0 && out_valid) or_low_left--;
   endtask

   task automatic idle();
      step(1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic send_pair(input logic [15:0] d, input logic [15:0] c);
      int tries;
      tries = 0;
      accepted = 1'b0;
      while (!accepted && tries < 50) begin
         step(1'b1, d, c, 1'b0);
         tries++;
      end
      check_val("pair_accept", {31'd0, accepted}, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || out_valid) && n < 200) begin
         idle();
         n++;
      end
      repeat (4) idle();
      check_val("drain_empty", exp_q.size(), 32'd0);
   endtask

   // Guard against a hung run.
   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      // Reset state
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_data_out", {16'd0, data_out}, 32'd0);
      check_val("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      #9 rst_n = 1'b1;

      // Test 1: constant pairs, latency and value
      first_ov_cyc = -1;
      repeat (TAPS) send_pair(16'h1000, 16'h4000);
      base = last_acc_cyc;
      drain();
      check_val("t1_latency", first_ov_cyc - base, 32'd2);
      check_val("t1_data", {16'd0, last_out}, 32'h3000);
      check_val("t1_ovf", {31'd0, last_ovf}, 32'd0);

      // Test 2: full-scale products
      repeat (TAPS) send_pair(16'h7FFF, 16'h7FFF);
      drain();
`ifdef MAC_L1_SAT_EN
      check_val("t2_data", {16'd0, last_out}, 32'h7FFF);
      check_val("t2_ovf", {31'd0, last_ovf}, 32'd1);
`else
      check_val("t2_data", {16'd0, last_out}, 32'hFFF4);
      check_val("t2_ovf", {31'd0, last_ovf}, 32'd0);
`endif

      // Test 3: two back-to-back results with a 5-cycle downstream stall
      base = results_seen;
      stall_cnt = 0;
      or_low_left = 5;
      repeat (2 * TAPS) send_pair(16'($urandom), 16'($urandom));
      drain();
      check_val("t3_results", results_seen - base, 32'd2);
      check_val("t3_stall_cycles", stall_cnt, 32'd5);

      // Test 4: alternating signs with gaps between pairs
      for (int i = 0; i < TAPS; i++) begin
         send_pair((i % 2 == 0) ? 16'h2000 : 16'hE000, 16'h7FFF);
         idle();
      end
      drain();
      check_val("t4_data", {16'd0, last_out}, 32'h0000);

      // Test 5: clear discards a partial group
      base = results_seen;
      repeat (3) send_pair(16'h1000, 16'h4000);
      repeat (3) idle();
      step(1'b0, 16'h0000, 16'h0000, 1'b1);
      repeat (TAPS) send_pair(16'h1000, 16'h4000);
      drain();
      check_val("t5_results", results_seen - base, 32'd1);
      check_val("t5_data", {16'd0, last_out}, 32'h3000);

      // Test 5b: clear on the same edge the group would complete
      base = results_seen;
      repeat (TAPS) send_pair(16'h0800, 16'h4000);
      step(1'b0, 16'h0000, 16'h0000, 1'b1);
      check_val("t5b_pending", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      drain();
      check_val("t5b_results", results_seen - base, 32'd0);

      // Test 6: asynchronous reset in the middle of a group
      repeat (4) send_pair(16'h1234, 16'h0567);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("t6_data_out", {16'd0, data_out}, 32'd0);
      check_val("t6_in_ready", {31'd0, in_ready}, 32'd0);
      model_taps = 0;
      model_sum  = 0;
      exp_q.delete();
      prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first_ov_cyc = -1;
      repeat (TAPS) send_pair(16'h1000, 16'h4000);
      base = last_acc_cyc;
      drain();
      check_val("t6_latency", first_ov_cyc - base, 32'd2);
      check_val("t6_data", {16'd0, last_out}, 32'h3000);

      // Random traffic with random gaps and random downstream backpressure
      or_rand = 1'b1;
      base = results_seen;
      for (int i = 0; i < 10 * TAPS; i++) begin
         if ($urandom_range(2, 0) == 0) idle();
         send_pair(16'($urandom), 16'($urandom));
      end
      drain();
      check_val("rand_results", results_seen - base, 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
